keccak_absorb_loader: RTL

Sponge-absorb front end for the Keccak-f[1600] permutation datapath (Theta → Rho → Pi → Chi → Iota). It accepts message lanes 64 bits at a time and XORs each lane into a held 1600-bit state. When a block is complete it presents the full state to the permutation. It then waits for the permuted state to come back before absorbing the next block. Padding is done upstream; this block only loads and XORs.

---
 rtl/keccak_pkg.sv | 21 ++
 rtl/keccak_absorb_loader_if.sv | 32 +++
 rtl/keccak_absorb_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants, lane addressing helper and the absorb FSM encoding.
// The permutation round stages use the same constants.
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int STATE_W   = 1600;
    localparam int IDX_W     = 5;

    typedef enum logic [1:0] {
        FSM_FILL      = 2'd0,
        FSM_PRESENT   = 2'd1,
        FSM_WAIT_PERM = 2'd2
    } fsm_e;

    // Lane k = x+5y occupies state bits 64k+z, z = 0..63.
    function automatic int lane_base(input int k);
        return k * LANE_W;
    endfunction

endpackage

// File: rtl/keccak_absorb_loader_if.sv
// Lane input channel, state-to-permutation channel and permuted-state return for the absorb loader.
// A transfer on either valid/ready pair happens on the rising clock edge where both are high;
// valid may not depend on ready, and the source holds its payload until the transfer completes.
interface keccak_absorb_loader_if;
    import keccak_pkg::*;

    logic [LANE_W-1:0]  i_lane;
    logic               i_lane_valid;
    logic               i_lane_last;
    logic               o_lane_ready;
    logic               i_clear;
    logic [0:STATE_W-1] o_state;
    logic               o_state_valid;
    logic               i_state_ready;
    logic [0:STATE_W-1] i_perm_state;
    logic               i_perm_valid;
    logic               o_busy;
    logic [1:0]         o_dbg_fsm;

    modport slave (
        input  i_lane, i_lane_valid, i_lane_last, i_clear,
        input  i_state_ready, i_perm_state, i_perm_valid,
        output o_lane_ready, o_state, o_state_valid, o_busy, o_dbg_fsm
    );

    modport master (
        output i_lane, i_lane_valid, i_lane_last, i_clear,
        output i_state_ready, i_perm_state, i_perm_valid,
        input  o_lane_ready, o_state, o_state_valid, o_busy, o_dbg_fsm
    );

endinterface

// File: rtl/keccak_absorb_loader.sv
// Sponge-absorb front end: XORs 64-bit lanes into a held 1600-bit state, presents the full
// state to the permutation, then reloads the permuted state as the base for the next block.
module keccak_absorb_loader
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = 17
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    keccak_absorb_loader_if.slave bus
);

    localparam logic [1:0] ST_FILL      = FSM_FILL;
    localparam logic [1:0] ST_PRESENT   = FSM_PRESENT;
    localparam logic [1:0] ST_WAIT_PERM = FSM_WAIT_PERM;

    logic [1:0]       r_fsm;
    logic [1:0]       w_fsm_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_lane_ready;

    logic               w_lane_hs;
    logic               w_last_hs;
    logic               w_clear;
    logic               w_perm_load;
    logic [STATE_W-1:0] w_state;
    logic [STATE_W-1:0] w_perm_state;

    // Ready is registered so it stays low while reset is asserted and for the release edge.
    assign w_lane_hs   = r_lane_ready && bus.i_lane_valid;
    assign w_last_hs   = w_lane_hs && (bus.i_lane_last || (r_idx == IDX_W'(RATE_LANES - 1)));
    assign w_clear     = (r_fsm == ST_FILL) && bus.i_clear && (r_idx == '0);
    assign w_perm_load = (r_fsm == ST_WAIT_PERM) && bus.i_perm_valid;

    always_comb begin
        for (int i = 0; i < STATE_W; i++) begin
            w_perm_state[i] = bus.i_perm_state[i];
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int B = lane_base(k);

        logic              w_we;
        logic [LANE_W-1:0] w_base;
        logic [LANE_W-1:0] r_lane;

        assign w_we   = w_lane_hs && (r_idx == IDX_W'(k));
        // A clear at index 0 takes effect before the XOR of a lane written in the same cycle.
        assign w_base = w_clear ? '0 : r_lane;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_lane <= '0;
            end else if (w_perm_load) begin
                r_lane <= w_perm_state[B +: LANE_W];
            end else if (w_we) begin
                r_lane <= w_base ^ bus.i_lane;
            end else if (w_clear) begin
                r_lane <= '0;
            end
        end

        assign w_state[B +: LANE_W] = r_lane;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_FILL:      if (w_last_hs) w_fsm_nxt = ST_PRESENT;
            ST_PRESENT:   if (bus.i_state_ready) w_fsm_nxt = ST_WAIT_PERM;
            ST_WAIT_PERM: if (bus.i_perm_valid) w_fsm_nxt = ST_FILL;
            default:      w_fsm_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm        <= ST_FILL;
            r_idx        <= '0;
            r_lane_ready <= 1'b0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_lane_ready <= (w_fsm_nxt == ST_FILL);
            if (w_last_hs) begin
                r_idx <= '0;
            end else if (w_lane_hs) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < STATE_W; i++) begin
            bus.o_state[i] = w_state[i];
        end
    end

    assign bus.o_lane_ready  = r_lane_ready;
    assign bus.o_state_valid = (r_fsm == ST_PRESENT);
    assign bus.o_busy        = (r_fsm == ST_PRESENT) || (r_fsm == ST_WAIT_PERM);
    assign bus.o_dbg_fsm     = r_fsm;

endmodule
